morse_decoder: RTL and testbench
================================

# morse_decoder

Morse code receiver: the counterpart of the board's switch-driven Morse transmitter. It samples a single pushbutton key, classifies each press as dot or dash from its duration, and detects the inter-letter gap. At the gap it decodes the accumulated pattern to a 5-bit letter index, using the same A=0..Z=25 encoding the transmitter takes on SW[4:0]. It sits between a KEY input and the LEDR/HEX display logic.

## Interface
- UNIT_CYCLES, 25000000: clock cycles per Morse time unit (0.5 s at 50 MHz).
- DEBOUNCE_CYCLES, 500000: cycles the synchronized key must be stable before a level change is accepted.
- CLOCK_50  input  1  system clock; all logic on its rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- key_n  input  1  raw pushbutton, active-low (pressed = 0), asynchronous to CLOCK_50.
- letter  output  5  last decoded letter index, 0..25.
- letter_valid  output  1  one-cycle pulse when `letter` is updated.
- error  output  1  one-cycle pulse on an undecodable pattern.
- pattern  output  4  symbols of the letter in progress; bit i is symbol i, 1 = dash.
- sym_count  output  3  number of symbols in `pattern`, 0..4.
- key_level  output  1  debounced key state, 1 = pressed.
- busy  output  1  high whenever state is not IDLE.

## Operation
- Input path: 2-FF synchronizer, then debouncer. `key_level` changes only after DEBOUNCE_CYCLES consecutive identical synchronized samples.
- Duration counter `cnt` is unsigned, width clog2(2*UNIT_CYCLES)+1. It saturates at 2*UNIT_CYCLES and clears on every state change.
- State IDLE:
  - `cnt`, `pattern` and `sym_count` are all 0.
  - When `key_level` = 1, go to MARK.
- State MARK: count while pressed. On release:
  - Symbol is dot if `cnt` < 2*UNIT_CYCLES, else dash.
  - If `sym_count` < 4, write the symbol to pattern[sym_count] and increment `sym_count`. Otherwise set the internal `ovf` flag.
  - Go to SPACE.
- State SPACE: count while released.
  - Press before `cnt` reaches 2*UNIT_CYCLES: go to MARK; same letter.
  - `cnt` reaches 2*UNIT_CYCLES: go to DECODE.
- State DECODE (one cycle):
  - Compare (`pattern`, `sym_count`) against the 26-entry table.
  - Match and !`ovf`: load `letter` and pulse `letter_valid`.
  - Otherwise: pulse `error`.
  - Clear `pattern`, `sym_count` and `ovf`; go to IDLE.
- A key held indefinitely saturates `cnt` and is classified as a dash on release.
- If the gap expires in the same cycle the key is pressed, the gap expiry wins. IDLE then sees the still-high `key_level` on the next cycle and enters MARK, so no press is lost.
- `letter` holds its value between pulses. `letter_valid` and `error` are never high together.

## Timing
- Reset values: `letter`=0, `letter_valid`=0, `error`=0, `pattern`=0, `sym_count`=0, `key_level`=0, `busy`=0, state=IDLE, synchronizer=released.
- Raw key edge to `key_level` edge: 2 + DEBOUNCE_CYCLES cycles.
- Last debounced release to `letter_valid`/`error`: 2*UNIT_CYCLES + 1 cycles (SPACE count, then DECODE). Both pulses are registered outputs.
- `pattern` and `sym_count` update on the cycle after the debounced release.
- Reset asserted mid-letter clears everything immediately. No pulse is emitted, and decoding restarts cleanly after deassertion.

## Configuration
- MORSE_DEC_ERR_EN defined:
  - `ovf` logic and table-miss detection are built in.
  - `error` pulses as described above.
- MORSE_DEC_ERR_EN undefined:
  - `error` is tied to 0 and `ovf` logic is removed.
  - Invalid or overflowing letters are silently discarded in DECODE.
  - All other behaviour is unchanged.

## Structure
- Package `morse_pkg`:
  - state enum (IDLE, MARK, SPACE, DECODE);
  - LETTER_W = 5, MAX_SYMS = 4;
  - constant 26-entry pattern/length table, shared with the transmitter.
- Sub-module `key_debouncer`: synchronizer plus stability counter, parameterized by DEBOUNCE_CYCLES.
- Everything else stays in `morse_decoder`.

## Test plan
All scenarios use UNIT_CYCLES=10 and DEBOUNCE_CYCLES=4.
- Press 10 cycles, release -> `letter`=4 (E), `letter_valid` high exactly 1 cycle, 21 cycles after the debounced release.
- Dot (10), gap 10, dash (30), gap 20 -> `pattern`=4'b0010, `sym_count`=2, then `letter`=0 (A).
- Four dashes -> `error` pulse with MORSE_DEC_ERR_EN; no pulse without it; `letter_valid` stays 0 in both builds.
- Five dots -> `sym_count` saturates at 4, `error` pulse (macro defined), state returns to IDLE.
- 2-cycle glitches on `key_n` -> `key_level` stays 0, `busy` stays 0.
- Reset asserted mid-MARK -> all outputs 0 at once; a following clean dot decodes to E.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared Morse definitions: decoder states, symbol limits and the A..Z code table
// used by both the transmitter and the receiver.
package morse_pkg;

  localparam int LETTER_W = 5;
  localparam logic [2:0] MAX_SYMS = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SPACE,
    DECODE
  } state_t;

  // Bit i of pat is symbol i (1 = dash); bits at or above len are always 0.
  typedef struct packed {
    logic [3:0] pat;
    logic [2:0] len;
  } code_t;

  typedef struct packed {
    logic                hit;
    logic [LETTER_W-1:0] idx;
  } decode_t;

  localparam code_t CODE_TABLE [26] = '{
    '{4'b0010, 3'd2},  // A .-
    '{4'b0001, 3'd4},  // B -...
    '{4'b0101, 3'd4},  // C -.-.
    '{4'b0001, 3'd3},  // D -..
    '{4'b0000, 3'd1},  // E .
    '{4'b0100, 3'd4},  // F ..-.
    '{4'b0011, 3'd3},  // G --.
    '{4'b0000, 3'd4},  // H ....
    '{4'b0000, 3'd2},  // I ..
    '{4'b1110, 3'd4},  // J .---
    '{4'b0101, 3'd3},  // K -.-
    '{4'b0010, 3'd4},  // L .-..
    '{4'b0011, 3'd2},  // M --
    '{4'b0001, 3'd2},  // N -.
    '{4'b0111, 3'd3},  // O ---
    '{4'b0110, 3'd4},  // P .--.
    '{4'b1011, 3'd4},  // Q --.-
    '{4'b0010, 3'd3},  // R .-.
    '{4'b0000, 3'd3},  // S ...
    '{4'b0001, 3'd1},  // T -
    '{4'b0100, 3'd3},  // U ..-
    '{4'b1000, 3'd4},  // V ...-
    '{4'b0110, 3'd3},  // W .--
    '{4'b1001, 3'd4},  // X -..-
    '{4'b1101, 3'd4},  // Y -.--
    '{4'b0011, 3'd4}   // Z --..
  };

  function automatic decode_t decode_letter(input logic [3:0] pat, input logic [2:0] len);
    decode_t r;
    r.hit = 1'b0;
    r.idx = '0;
    for (int i = 0; i < 26; i++) begin
      if (!r.hit && CODE_TABLE[i].pat == pat && CODE_TABLE[i].len == len) begin
        r.hit = 1'b1;
        r.idx = LETTER_W'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchronizer for an active-low pushbutton followed by a stability
// counter; key_level (1 = pressed) moves only after DEBOUNCE_CYCLES agreeing samples.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] stable_cnt;
  logic          pressed;

  assign pressed = ~sync2;

  // NOTE: every register here is updated with <= so all of them sample the
  // pre-edge values; blocking assignments would collapse the synchronizer stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      stable_cnt <= '0;
      key_level  <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      if (pressed != key_level) begin
        if (stable_cnt == STABLE_LAST) begin
          key_level  <= pressed;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + CW'(1);
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/morse_decoder.sv
// Morse receiver: times debounced key presses into dots/dashes and decodes each
// letter to an A=0..Z=25 index after the inter-letter gap. Optional: MORSE_DEC_ERR_EN.
module morse_decoder #(
  parameter int UNIT_CYCLES     = 25000000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       CLOCK_50,
  input  logic       reset_n,
  input  logic       key_n,
  output logic [4:0] letter,
  output logic       letter_valid,
  output logic       error,
  output logic [3:0] pattern,
  output logic [2:0] sym_count,
  output logic       key_level,
  output logic       busy
);

  import morse_pkg::*;

  localparam int CNT_W = $clog2(2 * UNIT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(2 * UNIT_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(2 * UNIT_CYCLES - 1);

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [3:0]          pattern_next;
  logic [2:0]          sym_count_next;
  logic [LETTER_W-1:0] letter_next;
  logic                letter_valid_next;
  decode_t             dec;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk      (CLOCK_50),
    .rst_n    (reset_n),
    .key_n    (key_n),
    .key_level(key_level)
  );

  assign dec  = decode_letter(pattern, sym_count);
  assign busy = (state != IDLE);

`ifdef MORSE_DEC_ERR_EN
  logic ovf, ovf_next;
  logic error_q, error_next;
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next        = state;
    pattern_next      = pattern;
    sym_count_next    = sym_count;
    letter_next       = letter;
    letter_valid_next = 1'b0;
`ifdef MORSE_DEC_ERR_EN
    ovf_next          = ovf;
    error_next        = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (key_level) state_next = MARK;
      end
      MARK: begin
        if (!key_level) begin
          state_next = SPACE;
          if (sym_count < MAX_SYMS) begin
            pattern_next[sym_count[1:0]] = (cnt == CNT_MAX);
            sym_count_next               = sym_count + 3'd1;
          end
`ifdef MORSE_DEC_ERR_EN
          else begin
            ovf_next = 1'b1;
          end
`endif
        end
      end
      SPACE: begin
        // The decode result is registered on entry to DECODE so the pulse is
        // visible for exactly the one cycle spent there; gap expiry beats a press.
        if (cnt == GAP_LAST) begin
          state_next = DECODE;
`ifdef MORSE_DEC_ERR_EN
          if (dec.hit && !ovf) begin
            letter_valid_next = 1'b1;
            letter_next       = dec.idx;
          end else begin
            error_next = 1'b1;
          end
`else
          if (dec.hit) begin
            letter_valid_next = 1'b1;
            letter_next       = dec.idx;
          end
`endif
        end else if (key_level) begin
          state_next = MARK;
        end
      end
      DECODE: begin
        state_next     = IDLE;
        pattern_next   = '0;
        sym_count_next = '0;
`ifdef MORSE_DEC_ERR_EN
        ovf_next       = 1'b0;
`endif
      end
      default: state_next = IDLE;
    endcase

    if (state == IDLE || state_next != state) begin
      cnt_next = '0;
    end else if (cnt != CNT_MAX) begin
      cnt_next = cnt + CNT_W'(1);
    end else begin
      cnt_next = cnt;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      pattern      <= '0;
      sym_count    <= '0;
      letter       <= '0;
      letter_valid <= 1'b0;
`ifdef MORSE_DEC_ERR_EN
      ovf          <= 1'b0;
      error_q      <= 1'b0;
`endif
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      pattern      <= pattern_next;
      sym_count    <= sym_count_next;
      letter       <= letter_next;
      letter_valid <= letter_valid_next;
`ifdef MORSE_DEC_ERR_EN
      ovf          <= ovf_next;
      error_q      <= error_next;
`endif
    end
  end

endmodule

// File: tb/tb_morse_decoder.sv
// Scoreboard bench for morse_decoder: stimulus queues expected letters/errors,
// a negedge monitor pops and checks them, including the release-to-pulse latency.
module tb_morse_decoder;

  localparam int UNIT     = 10;
  localparam int DEB      = 4;
  localparam int LATENCY  = 2 * UNIT + 1;

  logic       clk;
  logic       reset_n;
  logic       key_n;
  logic [4:0] letter;
  logic       letter_valid;
  logic       error;
  logic [3:0] pattern;
  logic [2:0] sym_count;
  logic       key_level;
  logic       busy;

  typedef struct {
    logic       is_err;
    logic [4:0] letter;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = 0;

  morse_decoder #(
    .UNIT_CYCLES    (UNIT),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .CLOCK_50    (clk),
    .reset_n     (reset_n),
    .key_n       (key_n),
    .letter      (letter),
    .letter_valid(letter_valid),
    .error       (error),
    .pattern     (pattern),
    .sym_count   (sym_count),
    .key_level   (key_level),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Raw key held low/high for n sampled edges; entry and exit are at posedge+1.
  task automatic press(input int n);
    key_n = 1'b0;
    repeat (n) @(posedge clk);
    #1 key_n = 1'b1;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_letter(input logic [4:0] l);
    exp_t e;
    e.is_err = 1'b0;
    e.letter = l;
    exp_q.push_back(e);
  endtask

  task automatic expect_error();
    exp_t e;
    e.is_err = 1'b1;
    e.letter = '0;
    exp_q.push_back(e);
  endtask

  // Monitor: decoupled from stimulus, compares every pulse against the queue.
  initial begin
    exp_t e;
    logic prev_level = 1'b0;
    logic prev_valid = 1'b0;
    int   last_fall  = 0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (letter_valid && error)
          check("valid_and_error_together", 32'(letter_valid & error), 32'd0);
        if (prev_valid && letter_valid)
          check("letter_valid_width", 32'(letter_valid), 32'd0);
        if ((letter_valid || error) && !prev_valid) begin
          if (exp_q.size() == 0) begin
            vectors = vectors + 1;
            miscompares = miscompares + 1;
            $display("FAIL unexpected_pulse: letter_valid=%0b error=%0b letter=%0d, none expected (cycle %0d)",
                     letter_valid, error, letter, cyc);
          end else begin
            e = exp_q.pop_front();
            check("pulse_is_error", 32'(error), 32'(e.is_err));
            if (!e.is_err) check("letter", 32'(letter), 32'(e.letter));
            check("release_to_pulse_latency", 32'(cyc - last_fall), 32'(LATENCY));
          end
        end
      end
      if (prev_level && !key_level) last_fall = cyc;
      prev_level = key_level;
      prev_valid = letter_valid;
    end
  end

  initial begin
    logic saw_level;
    logic saw_busy;

    reset_n = 1'b0;
    key_n   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_letter", 32'(letter), 32'd0);
    check("reset_letter_valid", 32'(letter_valid), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    check("reset_pattern", 32'(pattern), 32'd0);
    check("reset_sym_count", 32'(sym_count), 32'd0);
    check("reset_key_level", 32'(key_level), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    gap(5);

    // E: single dot
    expect_letter(5'd4);
    press(10);
    gap(10);
    check("e_sym_count", 32'(sym_count), 32'd1);
    check("e_pattern", 32'(pattern), 32'd0);
    gap(30);
    check("e_letter_held", 32'(letter), 32'd4);
    check("e_back_to_idle", 32'(busy), 32'd0);

    // A: dot, dash
    expect_letter(5'd0);
    press(10); gap(10); press(30);
    gap(10);
    check("a_pattern", 32'(pattern), 32'b0010);
    check("a_sym_count", 32'(sym_count), 32'd2);
    gap(30);

    // T: single dash
    expect_letter(5'd19);
    press(30);
    gap(40);

    // K: dash dot dash
    expect_letter(5'd10);
    press(30); gap(10); press(10); gap(10); press(30);
    gap(10);
    check("k_pattern", 32'(pattern), 32'b0101);
    gap(30);

    // Four dashes: not a letter
`ifdef MORSE_DEC_ERR_EN
    expect_error();
`endif
    for (int i = 0; i < 4; i++) begin
      press(30);
      gap(10);
    end
    check("dashes_pattern", 32'(pattern), 32'b1111);
    check("dashes_sym_count", 32'(sym_count), 32'd4);
    gap(30);
    check("letter_held_after_bad", 32'(letter), 32'd10);

`ifdef MORSE_DEC_ERR_EN
    // Five dots: symbol count saturates, overflow reported
    expect_error();
    for (int i = 0; i < 5; i++) begin
      press(10);
      gap(10);
    end
    check("ovf_sym_count", 32'(sym_count), 32'd4);
    gap(30);
    check("ovf_back_to_idle", 32'(busy), 32'd0);
    check("ovf_sym_count_cleared", 32'(sym_count), 32'd0);
`endif

    // Glitches shorter than the debounce window
    saw_level = 1'b0;
    saw_busy  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      key_n = 1'b0;
      repeat (2) begin
        @(negedge clk);
        saw_level = saw_level | key_level;
        saw_busy  = saw_busy | busy;
      end
      key_n = 1'b1;
      repeat (3) begin
        @(negedge clk);
        saw_level = saw_level | key_level;
        saw_busy  = saw_busy | busy;
      end
    end
    gap(10);
    check("glitch_key_level", 32'(saw_level), 32'd0);
    check("glitch_busy", 32'(saw_busy), 32'd0);

    // Reset in the middle of a mark
    key_n = 1'b0;
    gap(12);
    check("mid_mark_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_letter", 32'(letter), 32'd0);
    check("rst_pattern", 32'(pattern), 32'd0);
    check("rst_sym_count", 32'(sym_count), 32'd0);
    check("rst_key_level", 32'(key_level), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid_error", 32'({letter_valid, error}), 32'd0);
    key_n = 1'b1;
    gap(3);
    reset_n = 1'b1;
    gap(5);

    expect_letter(5'd4);
    press(10);
    gap(40);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    gap(40);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
